// File: rtl/data_select_arbiter.sv
// rtl/data_select_arbiter.sv - packet-granular round-robin select-token arbiter (optional grant counters: ARB_GRANT_STATS_EN)
module data_select_arbiter #(
   parameter int NUM_STREAMS = 4,
   parameter int MAX_BURST   = 1,
   parameter int STAT_W      = 32,
   localparam int SEL_W      = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_STREAMS-1:0]        req,
   output logic                          select_valid,
   input  logic                          select_ready,
   output logic [SEL_W-1:0]              select_data,
   output logic [NUM_STREAMS-1:0]        grant_onehot
`ifdef ARB_GRANT_STATS_EN
   ,
   output logic [NUM_STREAMS*STAT_W-1:0] grant_count,
   input  logic                          stats_clear
`endif
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   // Last burst index: a stream that has been granted this many extra times must rotate.
   localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

   state_t                   state_q, state_d;
   logic [SEL_W-1:0]         sel_q, sel_d;
   logic [SEL_W-1:0]         ptr_q, ptr_d;
   logic [7:0]               burst_q, burst_d;
   logic [NUM_STREAMS-1:0]   onehot_q, onehot_d;

   logic [2*NUM_STREAMS-1:0] req_dbl;
   logic [NUM_STREAMS-1:0]   req_rot;
   logic                     found;
   logic [SEL_W-1:0]         win;
   logic                     req_cur;
   logic                     handshake;

   // Index after idx, wrapping explicitly so non-power-of-two stream counts work.
   function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
      if (int'(idx) >= NUM_STREAMS - 1) begin
         return '0;
      end
      return idx + SEL_W'(1);
   endfunction

   function automatic logic [NUM_STREAMS-1:0] decode(input logic [SEL_W-1:0] idx);
      logic [NUM_STREAMS-1:0] v;
      v = '0;
      for (int i = 0; i < NUM_STREAMS; i++) begin
         if (int'(idx) == i) begin
            v[i] = 1'b1;
         end
      end
      return v;
   endfunction

   assign handshake = (state_q == S_GRANT) && select_ready;
   assign req_cur   = |(req & decode(sel_q));

   // Rotate req so bit 0 is the stream at ptr, then take the first set bit.
   // ptr always equals cur+1 while granting, so this also serves the rotation search.
   always_comb begin
      int sum;
      req_dbl = {req, req};
      req_rot = NUM_STREAMS'(req_dbl >> ptr_q);
      found   = 1'b0;
      win     = '0;
      sum     = 0;
      for (int i = 0; i < NUM_STREAMS; i++) begin
         if (!found && req_rot[i]) begin
            found = 1'b1;
            sum   = int'(ptr_q) + i;
            if (sum >= NUM_STREAMS) begin
               sum = sum - NUM_STREAMS;
            end
            win   = SEL_W'(sum);
         end
      end
   end

   // Next-state: load a winner from idle, hold until handshake, then burst, rotate or drain.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      burst_d = burst_q;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               state_d = S_GRANT;
               sel_d   = win;
               ptr_d   = next_idx(win);
               burst_d = '0;
            end
         end
         S_GRANT: begin
            if (select_ready) begin
               if ((burst_q < BURST_LAST) && req_cur) begin
                  burst_d = burst_q + 8'd1;
               end else if (found) begin
                  sel_d   = win;
                  ptr_d   = next_idx(win);
                  burst_d = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      onehot_d = (state_d == S_GRANT) ? decode(sel_d) : '0;
   end

   // State and token registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         sel_q    <= '0;
         ptr_q    <= '0;
         burst_q  <= '0;
         onehot_q <= '0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         ptr_q    <= ptr_d;
         burst_q  <= burst_d;
         onehot_q <= onehot_d;
      end
   end

   assign select_valid = (state_q == S_GRANT);
   assign select_data  = sel_q;
   assign grant_onehot = onehot_q;

`ifdef ARB_GRANT_STATS_EN
   logic [NUM_STREAMS*STAT_W-1:0] cnt_q, cnt_d;

   // Saturating per-stream handshake counters.
   always_comb begin
      cnt_d = cnt_q;
      for (int i = 0; i < NUM_STREAMS; i++) begin
         if (handshake && (int'(sel_q) == i) && (cnt_q[i*STAT_W +: STAT_W] != {STAT_W{1'b1}})) begin
            cnt_d[i*STAT_W +: STAT_W] = cnt_q[i*STAT_W +: STAT_W] + STAT_W'(1);
         end
      end
   end

   // Clear beats a same-cycle increment.
   always_ff @(posedge clk) begin
      if (rst || stats_clear) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign grant_count = cnt_q;
`else
   logic unused_handshake;
   assign unused_handshake = handshake;
`endif

endmodule

// File: doc/data_select_arbiter.md
Name: data_select_arbiter

Overview:
- Packet-granular round-robin arbiter that sits directly upstream of the stream data demultiplexer/multiplexer select port.
- Watches the valid lines of NUM_STREAMS packet streams and emits one select token (stream index) per packet on a ready/valid channel.
- The token is held until the downstream stage consumes it, which happens on the last beat of the routed packet.
- Optional burst mode lets one stream keep the grant for up to MAX_BURST consecutive packets.

Parameters:
- NUM_STREAMS, 4, number of arbitrated streams; legal range 1..64.
- MAX_BURST, 1, maximum consecutive packets granted to one stream before forced rotation; legal range 1..255.
- SEL_W, (NUM_STREAMS > 1 ? $clog2(NUM_STREAMS) : 1), width of the select index; derived, never overridden.
- STAT_W, 32, width of per-stream grant counters (optional feature only).

Ports:
- clk  in  1  single clock, all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- req  in  NUM_STREAMS  per-stream packet-pending indication (valid of each candidate stream).
- select_valid  out  1  select token valid.
- select_ready  in  1  token consumed by the downstream stage (asserted on the last beat of a packet).
- select_data  out  SEL_W  granted stream index.
- grant_onehot  out  NUM_STREAMS  one-hot decode of select_data, qualified by select_valid.
- grant_count  out  NUM_STREAMS*STAT_W  per-stream grant counters; only with ARB_GRANT_STATS_EN.
- stats_clear  in  1  clears grant_count; only with ARB_GRANT_STATS_EN.

Behaviour:
- Reset values: select_valid=0, select_data=0, grant_onehot=0, rr pointer=0, burst_cnt=0, state=IDLE, grant_count=0.
- All outputs are registered; there is no combinational path from req or select_ready to any output.
- State machine:
  - IDLE: when req != 0, winner = the first set bit searching ptr, ptr+1, ..., wrapping modulo NUM_STREAMS. The winner is registered, so select_valid rises the cycle after req is first seen (latency 1). Next state GRANT, burst_cnt=0.
  - GRANT: select_valid=1. select_data is stable until handshake (select_valid && select_ready). Dropping req[select_data] does not withdraw the token.
  - On handshake with burst continuation (burst_cnt < MAX_BURST-1 and req[cur]=1): keep cur and increment burst_cnt. The token is re-issued back-to-back, with select_valid held at 1.
  - On handshake otherwise: search starts at cur+1 and wraps, so cur is checked last. If a winner is found, load it with burst_cnt=0 and stay in GRANT (back-to-back, no bubble). If req is 0, go to IDLE and drop select_valid the next cycle.
  - ptr always becomes (last granted index + 1) mod NUM_STREAMS on rotation. The wrap from NUM_STREAMS-1 to 0 must be correct for non-power-of-two NUM_STREAMS.
  - req evaluation at handshake uses the req value in the handshake cycle.
- NUM_STREAMS=1: select_data is constant 0 and burst logic is irrelevant. Tokens are issued back-to-back while req[0]=1.
- MAX_BURST=1: pure round-robin, and burst_cnt is never incremented.
- Reset asserted mid-GRANT: the token is dropped (select_valid=0) the cycle after rst. Any partially routed packet is the downstream stage's concern.
- select_ready while select_valid=0: ignored, with no state change.

Optional Feature:
- Macro ARB_GRANT_STATS_EN.
- Defined:
  - grant_count holds one counter per stream, incremented on each handshake for that stream.
  - Counters saturate at all-ones.
  - stats_clear zeroes all counters synchronously and takes priority over a same-cycle increment.
  - rst also clears the counters.
- Undefined: grant_count and stats_clear ports and the counter logic are absent; behaviour is otherwise identical.

Test Plan:
- Basic latency and hold: NUM_STREAMS=4, req=4'b0100, select_ready=0 for 5 cycles -> select_valid=1 from cycle 1 after req, select_data=2 stable, grant_onehot=4'b0100; req dropped in cycle 3 -> token unchanged.
- Round-robin with wrap: req=4'b1111 held, select_ready=1 every cycle -> select_data sequence 0,1,2,3,0,1 with no bubble.
- Sparse rotation: req=4'b1001, ptr=0, select_ready=1 -> sequence 0,3,0,3.
- Burst: MAX_BURST=3, req=4'b0011 held, select_ready=1 -> 0,0,0,1,1,1,0.
- Burst break: MAX_BURST=3, req[0] dropped after the first stream-0 handshake -> next token is 1.
- Drain to idle and mid-grant reset:
  - req=0 at handshake -> select_valid=0 next cycle.
  - rst pulsed while select_data=2 is held -> select_valid=0; after reset with req=4'b1111 -> first token is 0.
- Stats (ARB_GRANT_STATS_EN, STAT_W=4):
  - 20 grants to stream 1 -> grant_count[1]=15 (saturated).
  - stats_clear in the same cycle as a handshake -> all counters 0.
